krnl_vadd_rtl_stream_combiner: RTL and testbench
================================================

# krnl_vadd_rtl_stream_combiner

Parametrised successor to the single-stream constant adder in the `krnl_vadd_rtl` kernel. The block joins `C_NUM_INPUTS` AXI4-Stream inputs beat by beat and computes a lane-wise sum plus a control constant, in wrapping or saturating mode. Results pass through a `C_PIPE_STAGES`-deep bubble-collapsing pipeline with full backpressure. It sits between the read-master FIFOs and the write-master FIFO, and adds beat/packet counters and a sticky tlast-mismatch flag.

## Interface
- `C_AXIS_TDATA_WIDTH`, default 512: data width of every stream.
- `C_ADDER_BIT_WIDTH`, default 32: lane width. `C_AXIS_TDATA_WIDTH` must be a multiple of it.
- `C_NUM_INPUTS`, default 4: number of joined input streams, range 1..8.
- `C_PIPE_STAGES`, default 2: register stages, range 1..4.
- `aclk` in 1: sole clock.
- `aresetn` in 1: reset, asynchronous assert, active-low, acts on all flops.
- `ctrl_constant` in `C_ADDER_BIT_WIDTH`: addend for every lane.
- `ctrl_mode` in 2: 0 = wrap sum, 1 = unsigned saturating sum, 2 = input 0 only plus constant, 3 = treated as 0.
- `s_axis_tvalid` in `C_NUM_INPUTS`: one bit per input.
- `s_axis_tready` out `C_NUM_INPUTS`: one bit per input.
- `s_axis_tdata` in `C_NUM_INPUTS*C_AXIS_TDATA_WIDTH`: input k in slice k.
- `s_axis_tkeep` in `C_NUM_INPUTS*C_AXIS_TDATA_WIDTH/8`: input k in slice k.
- `s_axis_tlast` in `C_NUM_INPUTS`: one bit per input.
- `m_axis_tvalid`, `m_axis_tready`, `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast`: single output stream, standard AXIS directions.
- `stat_beats` out 32: output beats transferred, wraps.
- `stat_packets` out 32: output beats with tlast set, wraps.
- `err_tlast_mismatch` out 1: sticky flag.
- `err_clear` in 1: synchronous clear of `err_tlast_mismatch`.

## Operation
- **Join**
  - `can_accept` = stage 1 empty, or stage 1 advancing this cycle.
  - `accept` = `&s_axis_tvalid && can_accept`.
  - Every `s_axis_tready[k]` = `&s_axis_tvalid && can_accept`, so all inputs transfer together or none does.
- **Control shadow**
  - `ctrl_constant` and `ctrl_mode` load into shadow registers only in cycles where the pipeline is empty and `accept`=0.
  - Otherwise the shadows hold, so a packet never sees a mid-stream change.
- **Lane arithmetic**, per lane i, in stage 1:
  - Compute sum = Σ input lanes (mode 2: input 0 lane only) + constant, at width `C_ADDER_BIT_WIDTH`+`$clog2(C_NUM_INPUTS+1)`.
  - Modes 0, 2, 3: keep the low `C_ADDER_BIT_WIDTH` bits.
  - Mode 1: if any upper bit is set, output all-ones.
- **Sideband**
  - `m_axis_tkeep` = input 0 tkeep.
  - `m_axis_tlast` = input 0 tlast.
  - If an accepted beat has `s_axis_tlast` not all-equal, set `err_tlast_mismatch`.
  - If set and clear occur in the same cycle, set wins.
- **Pipeline**
  - Each stage has a valid bit.
  - Stage n loads from n-1 when it is empty or is itself advancing.
  - The last stage drives `m_axis_*`. No combinational path from `s_axis_tdata` to `m_axis_tdata`.
- **Counters**
  - `stat_beats` increments on `m_axis_tvalid && m_axis_tready`.
  - `stat_packets` increments on the same condition with tlast set.
  - Both wrap from 0xFFFFFFFF to 0.

## Timing
- **Reset values:** all stage valids 0, `m_axis_tvalid` 0, `s_axis_tready` 0, `m_axis_tdata/tkeep/tlast` 0, counters 0, error 0, shadow constant 0, shadow mode 0.
- **Latency:** a beat accepted at cycle t appears at the output at t+`C_PIPE_STAGES` if unstalled.
- **Throughput:** one beat per cycle sustained.
- **Output stability:** once `m_axis_tvalid` is 1, data, keep and last stay stable until `m_axis_tready`.
- **Full pipeline:** with all stages full and `m_axis_tready`=0, `s_axis_tready`=0. On `m_axis_tready` rising, input is accepted the same cycle (ready ripples combinationally).
- **Partial valids:** if only some inputs are valid, nothing is accepted and all readies are 0.
- **Reset mid-packet:** all in-flight beats are dropped and counters are cleared. Upstream must restart the packet.

## Structure
- Shared package `krnl_vadd_rtl_pkg`:
  - mode localparams `MODE_WRAP`, `MODE_SAT`, `MODE_SINGLE`;
  - `$clog2`-based sum-width function.
- One sub-module, `krnl_vadd_rtl_pipe_stage`: one valid/data register with load/advance logic. Instantiate `C_PIPE_STAGES` times via generate.
- Lane arithmetic: generate loop in the top level.

## Test plan
- **Basic sum.** N=4, mode 0, constant 5, lanes 1/2/3/4, continuous valid and ready. Expect every lane = 15, beat out at t+2, one beat/cycle, `stat_beats`=16 after 16 beats.
- **Saturation.** Mode 1, lanes 0xFFFFFFF0 ×4, constant 1: expect 0xFFFFFFFF. Same inputs in mode 0: expect 0xFFFFFFC1.
- **Join stall.** Input 2 valid low for 5 cycles while the others are valid. Expect all `s_axis_tready`=0, no beat lost or duplicated, output order preserved.
- **Backpressure.** Hold `m_axis_tready` low 10 cycles mid-packet. Expect at most `C_PIPE_STAGES` beats in flight, held output stable, then 1 beat/cycle resumes.
- **tlast mismatch.** Input 1 tlast=1 while the others are 0. Expect `err_tlast_mismatch` set the next cycle, `stat_packets` unchanged, flag cleared by `err_clear`.
- **Control shadow and reset.** Change `ctrl_constant` mid-packet: output keeps the old constant until the pipeline drains. Assert `aresetn` low mid-packet: `m_axis_tvalid` goes 0 immediately and counters return to 0.

Source files
------------

// File: rtl/krnl_vadd_rtl_pkg.sv
// Shared definitions for the krnl_vadd_rtl stream combiner: control modes and
// width helpers used by the lane arithmetic.
package krnl_vadd_rtl_pkg;

  localparam logic [1:0] MODE_WRAP   = 2'd0;
  localparam logic [1:0] MODE_SAT    = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  localparam int unsigned STAT_WIDTH = 32;

  typedef logic [STAT_WIDTH-1:0] stat_t;

  // Summing n lanes plus the constant is n+1 terms, so the sum needs
  // clog2(n+1) guard bits above the lane width.
  function automatic int unsigned sum_width(int unsigned lane_width, int unsigned num_inputs);
    return lane_width + $clog2(num_inputs + 1);
  endfunction

  function automatic int unsigned keep_width(int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/krnl_vadd_rtl_pipe_stage.sv
// One bubble-collapsing pipeline register: loads when empty or when its own
// contents leave this cycle.
module krnl_vadd_rtl_pipe_stage #(
  parameter int unsigned C_WIDTH = 8
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               in_valid,
  input  logic [C_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [C_WIDTH-1:0] out_data,
  input  logic               out_ready
);

  logic               valid_q, valid_d;
  logic [C_WIDTH-1:0] data_q, data_d;

  assign in_ready = ~valid_q | out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      // Data only moves with a real beat, so a stalled output never changes.
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/krnl_vadd_rtl_stream_combiner.sv
// Joins C_NUM_INPUTS AXI4-Stream inputs beat by beat, adds lanes plus a
// shadowed constant (wrap/saturate/single) and emits through a stall-able pipe.
module krnl_vadd_rtl_stream_combiner
  import krnl_vadd_rtl_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_ADDER_BIT_WIDTH  = 32,
  parameter int unsigned C_NUM_INPUTS       = 4,
  parameter int unsigned C_PIPE_STAGES      = 2
) (
  input  logic                                           aclk,
  input  logic                                           aresetn,
  input  logic [C_ADDER_BIT_WIDTH-1:0]                   ctrl_constant,
  input  logic [1:0]                                     ctrl_mode,
  input  logic [C_NUM_INPUTS-1:0]                        s_axis_tvalid,
  output logic [C_NUM_INPUTS-1:0]                        s_axis_tready,
  input  logic [C_NUM_INPUTS*C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_NUM_INPUTS*C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [C_NUM_INPUTS-1:0]                        s_axis_tlast,
  output logic                                           m_axis_tvalid,
  input  logic                                           m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]                  m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]                m_axis_tkeep,
  output logic                                           m_axis_tlast,
  output logic [31:0]                                    stat_beats,
  output logic [31:0]                                    stat_packets,
  output logic                                           err_tlast_mismatch,
  input  logic                                           err_clear
);

  localparam int unsigned DataW  = C_AXIS_TDATA_WIDTH;
  localparam int unsigned LaneW  = C_ADDER_BIT_WIDTH;
  localparam int unsigned KeepW  = keep_width(C_AXIS_TDATA_WIDTH);
  localparam int unsigned NumLanes = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;
  localparam int unsigned SumW   = sum_width(C_ADDER_BIT_WIDTH, C_NUM_INPUTS);
  localparam int unsigned PipeW  = DataW + KeepW + 1;

  // ---------------------------------------------------------------------------
  // Join
  // ---------------------------------------------------------------------------
  logic                     all_valid;
  logic                     can_accept;
  logic                     accept;
  logic                     pipe_empty;
  logic                     tlast_mismatch;

  logic [C_PIPE_STAGES:0]   stage_valid;
  logic [C_PIPE_STAGES:0]   stage_ready;
  logic [PipeW-1:0]         stage_data [C_PIPE_STAGES+1];

  assign all_valid  = &s_axis_tvalid;
  assign can_accept = stage_ready[0];
  // Gating with aresetn keeps every ready low while reset is held.
  assign accept     = all_valid & can_accept & aresetn;
  assign s_axis_tready = {C_NUM_INPUTS{accept}};
  assign pipe_empty = ~|stage_valid[C_PIPE_STAGES:1];
  assign tlast_mismatch = ~(&s_axis_tlast | ~|s_axis_tlast);

  // ---------------------------------------------------------------------------
  // Control shadow: only refreshed while nothing is in flight or arriving
  // ---------------------------------------------------------------------------
  logic [LaneW-1:0] const_q, const_d;
  logic [1:0]       mode_q, mode_d;
  logic             sat_mode;
  logic             single_mode;

  always_comb begin
    const_d = const_q;
    mode_d  = mode_q;
    if (pipe_empty && !accept) begin
      const_d = ctrl_constant;
      mode_d  = ctrl_mode;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      const_q <= '0;
      mode_q  <= MODE_WRAP;
    end else begin
      const_q <= const_d;
      mode_q  <= mode_d;
    end
  end

  // Mode 3 falls through to plain wrapping arithmetic.
  assign sat_mode    = (mode_q == MODE_SAT);
  assign single_mode = (mode_q == MODE_SINGLE);

  // ---------------------------------------------------------------------------
  // Lane arithmetic
  // ---------------------------------------------------------------------------
  logic [DataW-1:0] lane_result;

  for (genvar i = 0; i < NumLanes; i++) begin : g_lane
    logic [SumW-1:0] sum;

    always_comb begin
      sum = SumW'(const_q);
      if (single_mode) begin
        sum = sum + SumW'(s_axis_tdata[i*LaneW +: LaneW]);
      end else begin
        for (int unsigned k = 0; k < C_NUM_INPUTS; k++) begin
          sum = sum + SumW'(s_axis_tdata[k*DataW + i*LaneW +: LaneW]);
        end
      end
    end

    assign lane_result[i*LaneW +: LaneW] =
        (sat_mode && (|sum[SumW-1:LaneW])) ? {LaneW{1'b1}} : sum[LaneW-1:0];
  end

  // Sideband follows input 0; the other tkeep slices carry no meaning here.
  logic unused_keep;
  assign unused_keep = ^s_axis_tkeep;

  // ---------------------------------------------------------------------------
  // Pipeline
  // ---------------------------------------------------------------------------
  assign stage_valid[0] = accept;
  assign stage_data[0]  = {s_axis_tlast[0], s_axis_tkeep[KeepW-1:0], lane_result};
  assign stage_ready[C_PIPE_STAGES] = m_axis_tready;

  for (genvar s = 0; s < C_PIPE_STAGES; s++) begin : g_stage
    krnl_vadd_rtl_pipe_stage #(
      .C_WIDTH (PipeW)
    ) u_stage (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .in_valid  (stage_valid[s]),
      .in_data   (stage_data[s]),
      .in_ready  (stage_ready[s]),
      .out_valid (stage_valid[s+1]),
      .out_data  (stage_data[s+1]),
      .out_ready (stage_ready[s+1])
    );
  end

  assign m_axis_tvalid = stage_valid[C_PIPE_STAGES];
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = stage_data[C_PIPE_STAGES];

  // ---------------------------------------------------------------------------
  // Statistics and error flag
  // ---------------------------------------------------------------------------
  stat_t beats_q, beats_d;
  stat_t packets_q, packets_d;
  logic  err_q, err_d;
  logic  out_fire;

  assign out_fire = m_axis_tvalid & m_axis_tready;

  always_comb begin
    beats_d   = beats_q;
    packets_d = packets_q;
    if (out_fire) begin
      beats_d = beats_q + stat_t'(1);
      if (m_axis_tlast) begin
        packets_d = packets_q + stat_t'(1);
      end
    end
  end

  // A new mismatch in the same cycle as a clear must survive.
  always_comb begin
    err_d = err_q;
    if (err_clear) begin
      err_d = 1'b0;
    end
    if (accept && tlast_mismatch) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beats_q   <= '0;
      packets_q <= '0;
      err_q     <= 1'b0;
    end else begin
      beats_q   <= beats_d;
      packets_q <= packets_d;
      err_q     <= err_d;
    end
  end

  assign stat_beats         = beats_q;
  assign stat_packets       = packets_q;
  assign err_tlast_mismatch = err_q;

endmodule

// File: tb/tb_krnl_vadd_rtl_stream_combiner.sv
// Randomised bench for the stream combiner, checked against a queue-based
// reference model of the join, arithmetic, shadow and counter rules.
module tb_krnl_vadd_rtl_stream_combiner;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned P  = 2;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned LANES = DW / AW;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            cyc;
  } exp_t;

  logic            aclk;
  logic            aresetn;
  logic [AW-1:0]   ctrl_constant;
  logic [1:0]      ctrl_mode;
  logic [N-1:0]    vld;
  logic [N-1:0]    rdy;
  logic [N*DW-1:0] dat;
  logic [N*KW-1:0] kp;
  logic [N-1:0]    lst;
  logic            m_tvalid;
  logic            m_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tlast;
  logic [31:0]     stat_beats;
  logic [31:0]     stat_packets;
  logic            err;
  logic            err_clear;

  krnl_vadd_rtl_stream_combiner #(
    .C_AXIS_TDATA_WIDTH (DW),
    .C_ADDER_BIT_WIDTH  (AW),
    .C_NUM_INPUTS       (N),
    .C_PIPE_STAGES      (P)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .ctrl_constant      (ctrl_constant),
    .ctrl_mode          (ctrl_mode),
    .s_axis_tvalid      (vld),
    .s_axis_tready      (rdy),
    .s_axis_tdata       (dat),
    .s_axis_tkeep       (kp),
    .s_axis_tlast       (lst),
    .m_axis_tvalid      (m_tvalid),
    .m_axis_tready      (m_tready),
    .m_axis_tdata       (m_tdata),
    .m_axis_tkeep       (m_tkeep),
    .m_axis_tlast       (m_tlast),
    .stat_beats         (stat_beats),
    .stat_packets       (stat_packets),
    .err_tlast_mismatch (err),
    .err_clear          (err_clear)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on plain 64-bit integers per lane.
  function automatic logic [DW-1:0] model_sum(input logic [N*DW-1:0] d, input logic [AW-1:0] c,
                                              input logic [1:0] m);
    logic [DW-1:0]   r;
    longint unsigned s;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      s = 64'(c);
      if (m == 2'd2) begin
        s = s + 64'(d[i*AW +: AW]);
      end else begin
        for (int k = 0; k < N; k++) s = s + 64'(d[k*DW + i*AW +: AW]);
      end
      if (m == 2'd1 && s > 64'hFFFF_FFFF) r[i*AW +: AW] = '1;
      else r[i*AW +: AW] = s[AW-1:0];
    end
    return r;
  endfunction

  // Model state.
  exp_t          q[$];
  logic [31:0]   mb, mp;
  logic          merr;
  logic [AW-1:0] sh_c;
  logic [1:0]    sh_m;
  int            cyc = 0;
  int            acc_total = 0;
  logic          acc_seen;
  logic          lat_chk = 1'b0;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic [KW-1:0] prev_keep;
  logic          prev_last;
  logic [DW-1:0] last_out;

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  initial begin : monitor
    int   sz;
    logic acc;
    logic all_v;
    exp_t e;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        q.delete();
        mb = '0; mp = '0; merr = 1'b0; sh_c = '0; sh_m = '0;
        acc_seen = 1'b0; prev_stall = 1'b0;
      end else begin
        sz    = q.size();
        all_v = &vld;
        acc   = all_v && rdy[0];
        check("s_tready", 512'(rdy), 512'({N{all_v && (sz < P || m_tready)}}));
        check("stat_beats", 512'(stat_beats), 512'(mb));
        check("stat_packets", 512'(stat_packets), 512'(mp));
        check("err_flag", 512'(err), 512'(merr));
        if (prev_stall) begin
          check("hold_valid", 512'(m_tvalid), 512'(1));
          check("hold_data", 512'(m_tdata), 512'(prev_data));
          check("hold_keep", 512'(m_tkeep), 512'(prev_keep));
          check("hold_last", 512'(m_tlast), 512'(prev_last));
        end
        if (m_tvalid && m_tready) begin
          if (sz == 0) begin
            check("spurious_beat", 512'(1), 512'(0));
          end else begin
            e = q.pop_front();
            check("tdata", 512'(m_tdata), 512'(e.data));
            check("tkeep", 512'(m_tkeep), 512'(e.keep));
            check("tlast", 512'(m_tlast), 512'(e.last));
            if (lat_chk) check("latency", 512'(cyc - e.cyc), 512'(P));
          end
          last_out = m_tdata;
          mb = mb + 32'd1;
          if (m_tlast) mp = mp + 32'd1;
        end
        if (err_clear) merr = 1'b0;
        if (acc && !((&lst) || !(|lst))) merr = 1'b1;
        if (sz == 0 && !acc) begin
          sh_c = ctrl_constant;
          sh_m = ctrl_mode;
        end
        if (acc) begin
          e.data = model_sum(dat, sh_c, sh_m);
          e.keep = kp[KW-1:0];
          e.last = lst[0];
          e.cyc  = cyc;
          q.push_back(e);
          acc_total++;
        end
        acc_seen   = acc;
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_keep  = m_tkeep;
        prev_last  = m_tlast;
      end
    end
  end

  // Stimulus helpers.
  logic [AW-1:0] fix_lane [N];
  logic [N-1:0]  fix_last;
  logic          rnd_ctrl = 1'b0;

  task automatic new_beat(input bit rnd);
    logic l;
    for (int k = 0; k < N; k++) begin
      for (int w = 0; w < LANES; w++) dat[k*DW + w*AW +: AW] = rnd ? $urandom : fix_lane[k];
      for (int w = 0; w < KW / 32; w++) kp[k*KW + w*32 +: 32] = rnd ? $urandom : 32'hFFFF_FFFF;
    end
    if (rnd) begin
      l   = ($urandom % 4) == 0;
      lst = {N{l}};
      if (($urandom % 16) == 0) lst[$urandom % N] = ~l;
    end else begin
      lst = fix_last;
    end
  endtask

  task automatic step(input int vld_pct, input int rdy_pct, input bit rnd);
    @(posedge aclk);
    #1;
    if (acc_seen) begin
      new_beat(rnd);
      vld = '0;
    end
    for (int k = 0; k < N; k++) if (!vld[k]) vld[k] = ($urandom % 100) < vld_pct;
    m_tready = ($urandom % 100) < rdy_pct;
    err_clear = 1'b0;
    if (rnd_ctrl) begin
      if (($urandom % 40) == 0) begin
        ctrl_constant = $urandom;
        ctrl_mode     = 2'($urandom % 4);
      end
      err_clear = ($urandom % 20) == 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
      vld = '0;
      m_tready = 1'b1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    vld = '0;
    m_tready = 1'b1;
    while (q.size() != 0 && t < 50) begin
      @(posedge aclk);
      #1;
      t++;
    end
    check("drain", 512'(q.size()), 512'(0));
    idle(1);
  endtask

  task automatic run_fixed(input int n);
    int start;
    int t;
    start = acc_total;
    t = 0;
    m_tready = 1'b1;
    vld = '1;
    while ((acc_total - start) < n && t < 200) begin
      @(posedge aclk);
      #1;
      t++;
    end
    vld = '0;
    check("run_fixed_count", 512'(acc_total - start), 512'(n));
  endtask

  logic [31:0] pk0;

  initial begin
    aresetn = 1'b0;
    ctrl_constant = '0;
    ctrl_mode = 2'd0;
    vld = '1;
    dat = '0;
    kp = '0;
    lst = '0;
    m_tready = 1'b1;
    err_clear = 1'b0;
    fix_last = '0;
    for (int k = 0; k < N; k++) fix_lane[k] = 32'(k + 1);

    // Reset state, with all inputs offering data.
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_tvalid", 512'(m_tvalid), 512'(0));
    check("rst_s_tready", 512'(rdy), 512'(0));
    check("rst_m_tdata", 512'(m_tdata), 512'(0));
    check("rst_m_tkeep", 512'(m_tkeep), 512'(0));
    check("rst_m_tlast", 512'(m_tlast), 512'(0));
    check("rst_stats", 512'({stat_beats, stat_packets}), 512'(0));
    check("rst_err", 512'(err), 512'(0));
    vld = '0;
    aresetn = 1'b1;

    // Basic sum: lanes 1..4 plus 5, 16 back-to-back beats.
    ctrl_constant = 32'd5;
    ctrl_mode = 2'd0;
    new_beat(1'b0);
    idle(2);
    lat_chk = 1'b1;
    run_fixed(16);
    drain();
    lat_chk = 1'b0;
    check("basic_lane", 512'(last_out[AW-1:0]), 512'(32'd15));
    check("basic_beats", 512'(stat_beats), 512'(16));

    // Saturating versus wrapping with large lanes.
    for (int k = 0; k < N; k++) fix_lane[k] = 32'hFFFF_FFF0;
    ctrl_constant = 32'd1;
    ctrl_mode = 2'd1;
    new_beat(1'b0);
    idle(2);
    run_fixed(2);
    drain();
    check("sat_lane", 512'(last_out[AW-1:0]), 512'(32'hFFFF_FFFF));
    ctrl_mode = 2'd0;
    idle(2);
    run_fixed(2);
    drain();
    check("wrap_lane", 512'(last_out[AW-1:0]), 512'(32'hFFFF_FFC1));

    // Single-input mode.
    ctrl_mode = 2'd2;
    idle(2);
    run_fixed(1);
    drain();
    check("single_lane", 512'(last_out[AW-1:0]), 512'(32'hFFFF_FFF1));
    ctrl_mode = 2'd0;

    // Join stall: input 2 withheld for five cycles.
    new_beat(1'b1);
    repeat (5) begin
      @(posedge aclk);
      #1;
      m_tready = 1'b1;
      vld = 4'b1011;
      #1;
      check("join_stall_rdy", 512'(rdy), 512'(0));
    end
    repeat (8) step(100, 100, 1'b1);
    drain();

    // Backpressure for ten cycles with continuous input.
    repeat (4) step(100, 100, 1'b1);
    repeat (10) begin
      step(100, 0, 1'b1);
      check("inflight_bound", 512'(q.size() <= P), 512'(1));
    end
    repeat (10) step(100, 100, 1'b1);
    drain();

    // tlast mismatch: input 1 alone flags last.
    for (int k = 0; k < N; k++) fix_lane[k] = 32'(k * 7);
    fix_last = 4'b0010;
    new_beat(1'b0);
    pk0 = stat_packets;
    run_fixed(1);
    check("err_set", 512'(err), 512'(1));
    drain();
    check("pkts_unchanged", 512'(stat_packets), 512'(pk0));
    err_clear = 1'b1;
    @(posedge aclk);
    #1;
    err_clear = 1'b0;
    check("err_cleared", 512'(err), 512'(0));
    fix_last = '0;

    // Constant change mid-stream under random backpressure.
    ctrl_constant = 32'd7;
    idle(2);
    repeat (5) step(100, 60, 1'b1);
    ctrl_constant = 32'd100;
    repeat (10) step(100, 60, 1'b1);
    drain();
    repeat (5) step(100, 100, 1'b1);
    drain();

    // Reset in the middle of a packet.
    repeat (6) step(100, 100, 1'b1);
    aresetn = 1'b0;
    #1;
    check("midrst_m_tvalid", 512'(m_tvalid), 512'(0));
    check("midrst_stats", 512'({stat_beats, stat_packets}), 512'(0));
    check("midrst_s_tready", 512'(rdy), 512'(0));
    repeat (2) @(posedge aclk);
    #1;
    vld = '0;
    aresetn = 1'b1;
    idle(2);

    // Fully random traffic including control changes and clears.
    rnd_ctrl = 1'b1;
    repeat (2000) step(70, 70, 1'b1);
    rnd_ctrl = 1'b0;
    err_clear = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
